// File: rtl/alu_pkg.sv
// Shared ALU op codes and FSM state encoding for the execute-side sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SRL) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_srl_iter.sv
// Iterative logical right shifter: one bit per cycle, counted down from shamt.
module alu_srl_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   value,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data
);

  logic [WIDTH-1:0]   sh;
  logic [SHAMT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= value;
      cnt <= shamt;
    end else if (cnt != '0) begin
      sh  <= sh >> 1;
      cnt <= cnt - SHAMT_W'(1);
    end
  end

  assign busy = (cnt != '0);
  // The last shift and the hand-off happen on the same edge, so expose the post-shift value.
  assign done = (cnt == SHAMT_W'(1));
  assign data = sh >> 1;

endmodule

// File: rtl/alu_seq_exec.sv
// Execute stage: single-cycle logic/arith ops, iterative SRL, valid/ready in and out.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic [1:0]         state;
  logic               accept;
  logic               srl_load;
  logic               srl_busy;
  logic               srl_done;
  logic [WIDTH-1:0]   srl_data;
  logic [SHAMT_W-1:0] shamt;

  function automatic logic [WIDTH-1:0] alu_comb(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SUB: return a + ~b + WIDTH'(1);
      ALU_SRL: return a;  // only reached with shamt == 0
      default: return '0;
    endcase
  endfunction

  assign shamt     = src_b[SHAMT_W-1:0];
  assign in_ready  = (state == ST_IDLE && !srl_busy) || (state == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign srl_load  = accept && (operation == ALU_SRL) && (shamt != '0);
  assign out_valid = (state == ST_DONE);
  assign zero      = out_valid && (result == '0);

  alu_srl_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_srl (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (srl_load),
    .value (src_a),
    .shamt (shamt),
    .busy  (srl_busy),
    .done  (srl_done),
    .data  (srl_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      result  <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      if (srl_load) begin
        state <= ST_SHIFT;
      end else begin
        state   <= ST_DONE;
        result  <= alu_comb(operation, src_a, src_b);
        illegal <= !op_legal(operation);
      end
    end else begin
      case (state)
        ST_SHIFT: if (srl_done) begin
          result  <= srl_data;
          illegal <= 1'b0;
          state   <= ST_DONE;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: ;
      endcase
    end
  end

endmodule
